montprod_param: RTL and testbench
=================================

Name: montprod_param

Overview:
- Parametrised, word-serial Montgomery product engine; next generation of the fixed 32-bit/256-word montprod.
- Computes result = A * B * R^-1 mod M, where R = 2^(WORD_W*length).
- Operands are read from external word memories; the result is written to an external result memory.
- Adds abort, operand validity checking, explicit done/error status and a guaranteed fully reduced result (< M).
- Sits under the modexp core, which drives it repeatedly for the square/multiply steps.

Parameters:
- WORD_W, 32, operand word width in bits (>= 8).
- ADDR_W, 8, operand address width; maximum operand length is 2^ADDR_W - 1 words.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- calculate  in  1  start pulse; sampled only while ready=1.
- abort  in  1  cancel the current operation; ignored while idle.
- length  in  ADDR_W  operand length in words; latched on accepted calculate.
- ready  out  1  high when idle and able to accept calculate.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on rejected operands.
- opa_addr  out  ADDR_W  A word address.
- opa_data  in  WORD_W  A word, combinational read of opa_addr.
- opb_addr  out  ADDR_W  B word address.
- opb_data  in  WORD_W  B word, combinational read.
- opm_addr  out  ADDR_W  M word address.
- opm_data  in  WORD_W  M word, combinational read.
- result_addr  out  ADDR_W  result word address.
- result_data  out  WORD_W  result word.
- result_we  out  1  result write enable, one word per cycle.

Behaviour:
- **Reset:**
  - ready=1; done=0; error=0; result_we=0.
  - All address outputs 0; result_data 0.
  - FSM in IDLE; internal S store contents don't-care.
- **Word order:** address 0 = most significant word; address length-1 = least significant word. Same convention for A, B, M and result.
- **Start:** calculate=1 while ready=1 latches length. ready drops on the next edge. calculate while busy is ignored.
- **FSM:** IDLE -> CHECK -> INIT -> ADD -> SHIFT -> (ADD for next bit | CMP) -> WRITE -> DONE -> IDLE.
- **CHECK (1 cycle):**
  - If length=0, or the LSB of M's least significant word (opm_addr=length-1) is 0, pulse error, perform no writes, return to IDLE.
  - Otherwise go to INIT.
- **INIT:** clear internal S (length words plus one overflow bit), length cycles.
- **Bit loop:** bits of A are processed LSB first (word length-1 down to word 0, bit 0 up to WORD_W-1); WORD_W*length iterations.
  - ADD computes S = S + a_i*B + q*M, LSW first, carry propagated, length cycles.
  - q = LSB of (S + a_i*B), determined before M is added.
  - SHIFT computes S = S >> 1, including the overflow bit, length cycles.
- **Invariant:** S < 2M whenever A, B < M.
- **CMP:** compare S against M, MSW first, with early exit allowed. The overflow bit set implies S >= M.
- **WRITE:** LSW first, result_we high for exactly length consecutive cycles.
  - result_addr runs length-1 down to 0.
  - result_data = S - M (borrow-propagated) if S >= M, else S.
- **DONE:** pulse done for 1 cycle; ready=1 on the following cycle.
- **Latency:** calculate to done <= WORD_W*length*(2*length+2) + 3*length + 8 cycles.
- **Writes:** result_we is never asserted outside WRITE. Each address is written exactly once per operation.
- **Abort:**
  - In any non-IDLE state, go to IDLE on the next edge.
  - result_we is deasserted immediately on that edge; done and error are not pulsed.
  - ready=1 within 1 cycle. Words already written remain undefined.
- **Simultaneous events:**
  - abort and calculate in the same cycle while idle: calculate is accepted, abort ignored.
  - Reset mid-operation: immediate return to reset state.
- **Operand ranges:** A >= M or B >= M give an unspecified result, but the block must still terminate with done.

Test Plan:
- length=1, A=0x9, B=0x7, M=0x13 -> done; result word0 = 0x00000001; exactly one write.
- length=1, A=0x11, B=0x7fffffff, M=0x10001 -> result word0 = 0x00007ff8.
- length=1, A=0x12, B=0x12, M=0x13 (exercises final subtraction) -> result 0x10; A=0 -> result 0.
- length=2, A={0,0x11}, B={0,0x13}, M={0,0x10001} -> word1=0x143, word0=0 (R≡1); writes at addr 1 then 0.
- length=0 -> error pulse after CHECK, no result_we, ready returns; M=0x12 (even) -> same.
- Abort asserted 50 cycles after calculate -> ready within 1 cycle, no done, no further result_we; a following A=0x9/B=0x7/M=0x13 operation still returns 1.

Source files
------------

// File: rtl/montprod_param_if.sv
// Bus interface of the word-serial Montgomery product engine.
//   slave  : engine side (montprod_param)
//   master : controller / operand memory side
// Signals:
//   calculate, abort, length         : command from the controller
//   ready, done, error               : status back to the controller
//   opa/opb/opm_addr, *_data         : combinational operand word reads
//   result_addr, result_data, _we    : result word writes
interface montprod_param_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
);
    logic              calculate;
    logic              abort;
    logic [ADDR_W-1:0] length;
    logic              ready;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] opa_addr;
    logic [WORD_W-1:0] opa_data;
    logic [ADDR_W-1:0] opb_addr;
    logic [WORD_W-1:0] opb_data;
    logic [ADDR_W-1:0] opm_addr;
    logic [WORD_W-1:0] opm_data;
    logic [ADDR_W-1:0] result_addr;
    logic [WORD_W-1:0] result_data;
    logic              result_we;

    modport master (
        output calculate, abort, length, opa_data, opb_data, opm_data,
        input  ready, done, error, opa_addr, opb_addr, opm_addr,
               result_addr, result_data, result_we
    );

    modport slave (
        input  calculate, abort, length, opa_data, opb_data, opm_data,
        output ready, done, error, opa_addr, opb_addr, opm_addr,
               result_addr, result_data, result_we
    );
endinterface

// File: rtl/montprod_param.sv
// Word-serial Montgomery product engine: result = A * B * R^-1 mod M,
// R = 2^(WORD_W*length). Operands are read one word per cycle from external
// memories (address 0 = most significant word); the fully reduced result is
// written back one word per cycle, least significant word first.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : command/status, operand reads and result writes (slave side)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready, waiting for calculate
// CHECK  | reject length 0 or even M
// INIT   | clear S, one word per cycle
// ADD    | S += a_i*B + q*M, LSW first, carry rippled across cycles
// SHIFT  | S >>= 1 including overflow, MSW first
// CMP    | S >= M ?  MSW first, early exit on first differing word
// WRITE  | emit S or S-M, LSW first
// DONE   | done pulse, ready returns next cycle
module montprod_param #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    montprod_param_if.slave   bus
);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ONE_A    = 1;
    localparam logic [BIT_W-1:0]  ONE_B    = 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_INIT, S_ADD, S_SHIFT, S_CMP, S_WRITE, S_DONE
    } state_t;

    state_t            state_q;
    logic              ready_q, done_q, error_q;
    logic [ADDR_W-1:0] len_q, idx_q, a_word_q;
    logic [BIT_W-1:0]  bit_q;
    logic [1:0]        carry_q;
    logic [1:0]        ovf_q;
    logic              q_q, first_q, sh_bit_q, ge_q, borrow_q;

    logic [WORD_W-1:0] s_mem [0:DEPTH-1];
    logic [WORD_W-1:0] s_rd, b_term, m_term, s_wdata_d;
    logic              s_we_d, a_bit, q_now;
    logic [WORD_W+1:0] sum;
    logic [WORD_W:0]   diff;
    logic [1:0]        ovf_sum;
    logic [ADDR_W-1:0] last;

    assign last = len_q - ONE_A;
    assign s_rd = s_mem[idx_q];

    always_comb begin
        a_bit  = bus.opa_data[bit_q];
        b_term = a_bit ? bus.opb_data : '0;
        // q only depends on the LSW, so it is taken on the first ADD cycle
        // and held for the rest of the word sweep.
        q_now  = first_q ? (s_rd[0] ^ (a_bit & bus.opb_data[0])) : q_q;
        m_term = q_now ? bus.opm_data : '0;
        sum    = {2'b00, s_rd} + {2'b00, b_term} + {2'b00, m_term}
               + {{WORD_W{1'b0}}, carry_q};
        // Sum of S (<2R) and two terms (<R each) stays below 4R: two bits.
        ovf_sum = ovf_q + sum[WORD_W+1:WORD_W];
        diff    = {1'b0, s_rd} - {1'b0, bus.opm_data} - {{WORD_W{1'b0}}, borrow_q};

        s_we_d    = 1'b0;
        s_wdata_d = '0;
        case (state_q)
            S_INIT:  s_we_d = 1'b1;
            S_ADD: begin
                s_we_d    = 1'b1;
                s_wdata_d = sum[WORD_W-1:0];
            end
            S_SHIFT: begin
                s_we_d    = 1'b1;
                s_wdata_d = {sh_bit_q, s_rd[WORD_W-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_we_d) s_mem[idx_q] <= s_wdata_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            a_word_q <= '0;
            bit_q    <= '0;
            carry_q  <= '0;
            ovf_q    <= '0;
            q_q      <= 1'b0;
            first_q  <= 1'b0;
            sh_bit_q <= 1'b0;
            ge_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (state_q != S_IDLE && bus.abort) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.calculate) begin
                            len_q   <= bus.length;
                            idx_q   <= bus.length - ONE_A;
                            ready_q <= 1'b0;
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        ovf_q <= '0;
                        if (len_q == '0 || !bus.opm_data[0]) begin
                            error_q <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        if (idx_q == '0) begin
                            state_q  <= S_ADD;
                            idx_q    <= last;
                            a_word_q <= last;
                            bit_q    <= '0;
                            carry_q  <= '0;
                            first_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q - ONE_A;
                        end
                    end
                    S_ADD: begin
                        q_q     <= q_now;
                        first_q <= 1'b0;
                        carry_q <= sum[WORD_W+1:WORD_W];
                        if (idx_q == '0) begin
                            // Low overflow bit shifts into the MSW, high bit
                            // becomes the new overflow.
                            sh_bit_q <= ovf_sum[0];
                            ovf_q    <= {1'b0, ovf_sum[1]};
                            state_q  <= S_SHIFT;
                        end else begin
                            idx_q <= idx_q - ONE_A;
                        end
                    end
                    S_SHIFT: begin
                        sh_bit_q <= s_rd[0];
                        if (idx_q == last) begin
                            idx_q   <= last;
                            carry_q <= '0;
                            first_q <= 1'b1;
                            state_q <= S_ADD;
                            if (bit_q == BIT_LAST) begin
                                bit_q <= '0;
                                if (a_word_q == '0) begin
                                    idx_q   <= '0;
                                    state_q <= S_CMP;
                                end else begin
                                    a_word_q <= a_word_q - ONE_A;
                                end
                            end else begin
                                bit_q <= bit_q + ONE_B;
                            end
                        end else begin
                            idx_q <= idx_q + ONE_A;
                        end
                    end
                    S_CMP: begin
                        if (ovf_q[0] || s_rd > bus.opm_data || s_rd < bus.opm_data
                            || idx_q == last) begin
                            // Equal all the way down also means S >= M.
                            ge_q     <= ovf_q[0] || !(s_rd < bus.opm_data);
                            idx_q    <= last;
                            borrow_q <= 1'b0;
                            state_q  <= S_WRITE;
                        end else begin
                            idx_q <= idx_q + ONE_A;
                        end
                    end
                    S_WRITE: begin
                        borrow_q <= diff[WORD_W];
                        if (idx_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q - ONE_A;
                        end
                    end
                    S_DONE: begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.opa_addr    = a_word_q;
    assign bus.opb_addr    = idx_q;
    assign bus.opm_addr    = idx_q;
    assign bus.result_addr = idx_q;
    // Result is a combinational function of the S store and the M word at
    // the current index, so write enable is decoded straight from the state.
    assign bus.result_we   = (state_q == S_WRITE);
    assign bus.result_data = (state_q == S_WRITE) ? (ge_q ? diff[WORD_W-1:0] : s_rd) : '0;
endmodule

// File: tb/tb_montprod_param.sv
module tb_montprod_param;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int LIMIT  = 3000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    montprod_param_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();
    montprod_param #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] mem_m [0:255];
    logic [31:0] mem_r [0:255];
    logic [7:0]  wr_log [0:4095];
    int          wr_total = 0;

    assign bus.opa_data = mem_a[bus.opa_addr];
    assign bus.opb_data = mem_b[bus.opb_addr];
    assign bus.opm_data = mem_m[bus.opm_addr];

    always @(negedge clk) begin
        if (bus.result_we) begin
            mem_r[bus.result_addr]  <= bus.result_data;
            wr_log[wr_total % 4096] <= bus.result_addr;
            wr_total                <= wr_total + 1;
        end
    end

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            mem_m[i] = '0;
            mem_r[i] = 32'hdeadbeef;
        end
    endtask

    task automatic run_op(input int len, input bit with_abort, output bit got_done,
                          output bit got_err, output int cyc, output int nwr, output int base);
        @(negedge clk);
        base          = wr_total;
        bus.length    = len[ADDR_W-1:0];
        bus.calculate = 1'b1;
        bus.abort     = with_abort;
        @(negedge clk);
        bus.calculate = 1'b0;
        bus.abort     = 1'b0;
        cyc = 1;
        check_eq("ready_drop", bus.ready, 1'b0);
        while (!bus.done && !bus.error && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        got_done = bus.done;
        got_err  = bus.error;
        @(negedge clk);
        nwr = wr_total - base;
        check_eq("ready_ret", bus.ready, 1'b1);
    endtask

    function automatic int lat_bound(input int len);
        return WORD_W * len * (2 * len + 2) + 3 * len + 8;
    endfunction

    // single-word directed vector
    task automatic vec1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] m, input logic [31:0] exp, input bit with_abort);
        bit d, e;
        int cyc, nwr, base;
        clear_mems();
        mem_a[0] = a;
        mem_b[0] = b;
        mem_m[0] = m;
        run_op(1, with_abort, d, e, cyc, nwr, base);
        check_eq({tag, "_done"}, d, 1'b1);
        check_eq({tag, "_err"}, e, 1'b0);
        check_eq({tag, "_nwr"}, nwr, 1);
        check_eq({tag, "_addr"}, wr_log[base % 4096], 8'd0);
        check_eq({tag, "_res"}, mem_r[0], exp);
        check_eq({tag, "_lat"}, cyc <= lat_bound(1), 1'b1);
    endtask

    initial begin
        bit d, e, saw;
        int cyc, nwr, base;

        reset_n       = 1'b0;
        bus.calculate = 1'b0;
        bus.abort     = 1'b0;
        bus.length    = '0;
        clear_mems();
        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.ready, 1'b1);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_error", bus.error, 1'b0);
        check_eq("rst_we", bus.result_we, 1'b0);
        check_eq("rst_addrs", {bus.opa_addr, bus.opb_addr, bus.opm_addr, bus.result_addr}, 32'h0);
        check_eq("rst_rdata", bus.result_data, 32'h0);
        reset_n = 1'b1;

        vec1("v9x7", 32'h9, 32'h7, 32'h13, 32'h1, 1'b0);
        vec1("v11x7fff", 32'h11, 32'h7fffffff, 32'h10001, 32'h7ff8, 1'b0);
        vec1("v12x12", 32'h12, 32'h12, 32'h13, 32'h10, 1'b0);
        vec1("v0x12", 32'h0, 32'h12, 32'h13, 32'h0, 1'b0);

        // two words, R == 1 mod M
        clear_mems();
        mem_a[1] = 32'h11;
        mem_b[1] = 32'h13;
        mem_m[1] = 32'h10001;
        run_op(2, 1'b0, d, e, cyc, nwr, base);
        check_eq("l2_done", d, 1'b1);
        check_eq("l2_nwr", nwr, 2);
        check_eq("l2_order", {wr_log[base % 4096], wr_log[(base + 1) % 4096]}, 16'h0100);
        check_eq("l2_res", {mem_r[0], mem_r[1]}, {32'h0, 32'h143});
        check_eq("l2_lat", cyc <= lat_bound(2), 1'b1);

        // M = 2^32+1, R = 2^64 == 1; A = 2^32 == -1, B = 3 -> M-3
        clear_mems();
        mem_a[0] = 32'h1;
        mem_b[1] = 32'h3;
        mem_m[0] = 32'h1;
        mem_m[1] = 32'h1;
        run_op(2, 1'b0, d, e, cyc, nwr, base);
        check_eq("wide1_done", d, 1'b1);
        check_eq("wide1_res", {mem_r[0], mem_r[1]}, {32'h0, 32'hfffffffe});

        // (-1)*(-1) = 1 mod 2^32+1
        mem_b[0] = 32'h1;
        mem_b[1] = 32'h0;
        run_op(2, 1'b0, d, e, cyc, nwr, base);
        check_eq("wide2_done", d, 1'b1);
        check_eq("wide2_res", {mem_r[0], mem_r[1]}, {32'h0, 32'h1});

        // rejected operands
        clear_mems();
        mem_m[0]   = 32'h13;
        mem_m[255] = 32'h13;
        run_op(0, 1'b0, d, e, cyc, nwr, base);
        check_eq("len0_err", e, 1'b1);
        check_eq("len0_done", d, 1'b0);
        check_eq("len0_nwr", nwr, 0);
        mem_a[0] = 32'h9;
        mem_b[0] = 32'h7;
        mem_m[0] = 32'h12;
        run_op(1, 1'b0, d, e, cyc, nwr, base);
        check_eq("even_err", e, 1'b1);
        check_eq("even_done", d, 1'b0);
        check_eq("even_nwr", nwr, 0);

        // abort mid-operation
        clear_mems();
        mem_a[0] = 32'h9;
        mem_b[0] = 32'h7;
        mem_m[0] = 32'h13;
        @(negedge clk);
        base          = wr_total;
        bus.length    = 8'd1;
        bus.calculate = 1'b1;
        @(negedge clk);
        bus.calculate = 1'b0;
        repeat (49) @(negedge clk);
        check_eq("abort_busy", bus.ready, 1'b0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort_ready", bus.ready, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            saw = saw | bus.done | bus.error;
        end
        check_eq("abort_nodone", saw, 1'b0);
        check_eq("abort_nwr", wr_total - base, 0);

        // calculate together with abort while idle: calculate wins
        vec1("after_abort", 32'h9, 32'h7, 32'h13, 32'h1, 1'b1);

        // reset in the middle of an operation
        @(negedge clk);
        bus.length    = 8'd1;
        bus.calculate = 1'b1;
        @(negedge clk);
        bus.calculate = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", bus.ready, 1'b1);
        check_eq("mid_rst_we", bus.result_we, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        vec1("after_rst", 32'h12, 32'h12, 32'h13, 32'h10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
